// File: rtl/uart_pkg.sv
// Shared types and helpers for the RS-232 receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversample tick; the fractional part is dropped.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/recv_uart_if.sv
// Byte delivery handshake plus status strobes of the UART receiver.
interface recv_uart_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_busy;

    modport master (output rx_data, rx_valid, frame_err, overrun, rx_busy, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, rx_busy, output rx_ready);
endinterface

// File: rtl/rx_baud_gen.sv
// Oversample tick divider: counts 0..DIV-1 and strobes tick at DIV-1.
module rx_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Divider is held at zero while cleared so phase restarts at the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (clr)     cnt <= '0;
        else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = en && !clr && (cnt == LAST);
endmodule

// File: rtl/recv_uart.sv
// RS-232 8N1 receiver: synchroniser, oversampled 2-of-3 vote, LSB-first
// shifter and a one-deep holding register with valid/ready.
module recv_uart
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    recv_uart_if.master link
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_A    = SW'(M - 1);
    localparam logic [SW-1:0] S_B    = SW'(M);
    localparam logic [SW-1:0] S_C    = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t              state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_prev, fall;
    logic                   tick, decide, last, maj;
    logic [SW-1:0]          s_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [1:0]             smp;
    logic [DATA_BITS-1:0]   rx_shift, data_q;
    logic                   valid_q, ferr_q, ovr_q;
    logic                   busy, stop_ok, stop_bad;

    // Synchroniser plus one history flop for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rs232_rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = rx_prev && !rx_s;

    rx_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (busy),
        .tick (tick)
    );

    assign decide = tick && (s_cnt == S_C);
    assign last   = tick && (s_cnt == S_LAST);
    assign maj    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    // Tick index within the current bit; parked at zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                s_cnt <= '0;
        else if (state == IDLE) s_cnt <= '0;
        else if (tick)          s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
    end

    // First two of the three mid-bit samples; the third is the live line at decide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         smp    <= '0;
        else if (tick && s_cnt == S_A)   smp[0] <= rx_s;
        else if (tick && s_cnt == S_B)   smp[1] <= rx_s;
    end

    // Data bit index, advanced at the end of every data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 bit_cnt <= '0;
        else if (state != DATA)  bit_cnt <= '0;
        else if (last)           bit_cnt <= bit_cnt + 1'b1;
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          rx_shift <= '0;
        else if (state == DATA && decide) rx_shift <= {maj, rx_shift[DATA_BITS-1:1]};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; STOP leaves at the vote so an early next start edge is caught.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (decide && maj) state_nxt = IDLE;
                   else if (last)     state_nxt = DATA;
            DATA:  if (last && bit_cnt == B_LAST) state_nxt = STOP;
            STOP:  if (decide) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and stop-bit verdict strobes.
    always_comb begin
        busy     = (state != IDLE);
        stop_ok  = (state == STOP) && decide && maj;
        stop_bad = (state == STOP) && decide && !maj;
    end

    // Holding register: load when empty or being drained this cycle, else flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            ovr_q  <= stop_ok && valid_q && !link.rx_ready;
            if (stop_ok && (!valid_q || link.rx_ready)) begin
                data_q  <= rx_shift;
                valid_q <= 1'b1;
            end else if (valid_q && link.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign link.rx_data   = data_q;
    assign link.rx_valid  = valid_q;
    assign link.frame_err = ferr_q;
    assign link.overrun   = ovr_q;
    assign link.rx_busy   = busy;
endmodule

// File: tb/tb_recv_uart.sv
// Bench for recv_uart: 16 clk per bit, line-level reference model that
// derives every output from the recorded line history and sample times.
module tb_recv_uart;
    localparam int HSZ = 65536;

    logic clk = 1'b0;
    logic rst;
    logic rs232_rx;
    bit   rand_rdy;

    recv_uart_if link();

    recv_uart #(
        .CLK_HZ      (1_600_000),
        .BAUD        (100_000),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .link     (link)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, link.rx_busy, link.rx_valid, link.frame_err, link.overrun, link.rx_data};
    endfunction

    // ---------------- reference model ----------------
    // line_h[e] = line value captured by the synchroniser at clock edge e.
    // A frame whose line fall is first seen at edge F has bit k voted from
    // line_h[F+16k+8 .. F+16k+10]; START appears at F+2, the glitch verdict
    // lands at F+12 and the stop verdict (and byte/error) at F+156.
    bit          line_h [HSZ];
    int          n = 4;
    int          fr_f = 0;
    bit          m_busy = 0, m_valid = 0, m_fe = 0, m_ov = 0;
    logic [7:0]  m_data = 8'h00;

    // DUT-side observations
    int          d_acc = 0, d_fe = 0, d_ov = 0, d_vcyc = 0, run = 0, last_run = 0;
    logic [7:0]  d_last = 8'h00;

    function automatic bit maj3(input int i);
        return (int'(line_h[i]) + int'(line_h[i+1]) + int'(line_h[i+2])) >= 2;
    endfunction

    initial begin
        bit          was_busy, done;
        logic [7:0]  nb;
        logic [31:0] exp;
        for (int i = 0; i < HSZ; i++) line_h[i] = 1'b1;
        forever begin
            @(posedge clk);
            was_busy = m_busy;
            done     = 1'b0;
            nb       = 8'h00;
            m_fe     = 1'b0;
            m_ov     = 1'b0;
            if (rst) begin
                line_h[n] = 1'b1;
                m_busy    = 1'b0;
                m_valid   = 1'b0;
                m_data    = 8'h00;
            end else begin
                line_h[n] = rs232_rx;
                if (was_busy && n == fr_f + 12 && maj3(fr_f + 8)) m_busy = 1'b0;
                if (was_busy && n == fr_f + 156) begin
                    m_busy = 1'b0;
                    if (maj3(fr_f + 152)) begin
                        done = 1'b1;
                        for (int i = 0; i < 8; i++) nb[i] = maj3(fr_f + 16*(i+1) + 8);
                    end else begin
                        m_fe = 1'b1;
                    end
                end
                if (!was_busy && line_h[n-2] == 1'b0 && line_h[n-3] == 1'b1) begin
                    m_busy = 1'b1;
                    fr_f   = n - 2;
                end
                if (done) begin
                    if (!m_valid || link.rx_ready) begin
                        m_data  = nb;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else if (m_valid && link.rx_ready) begin
                    m_valid = 1'b0;
                end
            end
            if (n < HSZ - 1) n++;

            @(negedge clk);
            if (link.rx_valid && link.rx_ready) begin
                d_acc++;
                d_last = link.rx_data;
            end
            if (link.frame_err) d_fe++;
            if (link.overrun)   d_ov++;
            if (link.rx_valid)  d_vcyc++;
            if (link.rx_busy) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            exp = rst ? 32'd0 : {20'd0, m_busy, m_valid, m_fe, m_ov, m_data};
            chk("outputs", outs(), exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int cycles);
        rs232_rx = 1'b1;
        repeat (cycles) begin
            if (rand_rdy) link.rx_ready = ($urandom & 1) != 0;
            step();
        end
    endtask

    // hp = half-clocks per bit (32 nominal, 31 = ~3% fast); bit k starts at floor(k*hp/2).
    // Returns early, without advancing, once cycle stop_at has been driven.
    task automatic send(input logic [7:0] b, input bit stop_bit, input int hp, input int stop_at);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int c = 0; c < 5*hp; c++) begin
            if (rand_rdy) link.rx_ready = ($urandom & 1) != 0;
            rs232_rx = fr[(2*c + 1) / hp];
            if (c == stop_at) return;
            step();
        end
    endtask

    initial begin
        int a0, f0, o0, v0;
        rst = 1'b1;
        rs232_rx = 1'b1;
        link.rx_ready = 1'b1;
        rand_rdy = 1'b0;
        repeat (4) step();
        chk("reset_state", outs(), 32'd0);
        rst = 1'b0;
        idle(10);

        // 1: clean frame, consumer always ready
        a0 = d_acc; f0 = d_fe; o0 = d_ov; v0 = d_vcyc;
        send(8'hA5, 1'b1, 32, -1);
        idle(10);
        chk("t1_accepted", d_acc - a0, 1);
        chk("t1_data", d_last, 8'hA5);
        chk("t1_model_data", m_data, 8'hA5);
        chk("t1_valid_cycles", d_vcyc - v0, 1);
        chk("t1_errors", (d_fe - f0) + (d_ov - o0), 0);

        // 2: 4-clk low glitch on idle line
        a0 = d_acc; f0 = d_fe; o0 = d_ov; v0 = d_vcyc;
        rs232_rx = 1'b0;
        repeat (4) step();
        idle(30);
        chk("t2_busy_len_ok", (last_run > 0 && last_run <= 16) ? 1 : 0, 1);
        chk("t2_no_output", (d_vcyc - v0) + (d_fe - f0) + (d_ov - o0), 0);

        // 3: bad stop bit, then a good byte
        a0 = d_acc; f0 = d_fe; v0 = d_vcyc;
        send(8'h3C, 1'b0, 32, -1);
        idle(10);
        chk("t3_frame_err", d_fe - f0, 1);
        chk("t3_no_valid", d_vcyc - v0, 0);
        send(8'h55, 1'b1, 32, -1);
        idle(10);
        chk("t3_next_data", d_last, 8'h55);
        chk("t3_next_count", d_acc - a0, 1);

        // 4: overrun while consumer stalls
        o0 = d_ov;
        link.rx_ready = 1'b0;
        send(8'h11, 1'b1, 32, -1);
        idle(5);
        send(8'h22, 1'b1, 32, -1);
        idle(10);
        chk("t4_held_data", link.rx_data, 8'h11);
        chk("t4_held_valid", link.rx_valid, 1);
        chk("t4_overrun", d_ov - o0, 1);
        link.rx_ready = 1'b1;
        step();
        link.rx_ready = 1'b0;
        chk("t4_drained", link.rx_valid, 0);
        link.rx_ready = 1'b1;
        idle(5);

        // 5: back-to-back fast frames, no idle gap
        a0 = d_acc; f0 = d_fe; o0 = d_ov;
        send(8'h00, 1'b1, 31, -1);
        send(8'hFF, 1'b1, 31, -1);
        idle(10);
        chk("t5_count", d_acc - a0, 2);
        chk("t5_last", d_last, 8'hFF);
        chk("t5_errors", (d_fe - f0) + (d_ov - o0), 0);

        // 6: reset in data bit 4, then recover
        send(8'h81, 1'b1, 32, 88);
        rst = 1'b1;
        #1;
        chk("t6_async_reset", outs(), 32'd0);
        rs232_rx = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        idle(10);
        a0 = d_acc;
        send(8'h7E, 1'b1, 32, -1);
        idle(10);
        chk("t6_after_reset", d_last, 8'h7E);
        chk("t6_count", d_acc - a0, 1);

        // randomized frames, gaps, rates and consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), ($urandom % 8) != 0, (($urandom % 4) == 0) ? 31 : 32, -1);
            idle($urandom_range(0, 12));
        end
        rand_rdy = 1'b0;
        link.rx_ready = 1'b1;
        idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
